irq_requester: RTL and testbench

IRQ_REQUESTER -- requirements
Module: irq_requester

---
 rtl/irq_requester.sv | 172 +++++++++++++++++
 tb/tb_irq_requester.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_requester.sv
// Three-line interrupt requester: synchronizes and debounces keys, latches pending
// requests and raises one registered request at a time, with acknowledge and timeout.
module irq_requester #(
    parameter int DB_CYCLES   = 16,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [2:0]         key_in,
    input  logic [2:0]         running_in,
    output logic [2:0]         irq_out,
    output logic [2:0]         pending,
    output logic [1:0]         active_level,
    output logic [2:0]         lost_req,
    output logic               timeout,
    output logic [3*CNT_W-1:0] svc_count,
    output logic               dbg_state
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_stable;
    logic [DB_W-1:0]  r_db_cnt [3];
    logic [2:0]       w_db_done;
    logic [2:0]       w_event;

    state_t           r_state;
    logic [1:0]       r_grant;
    logic [2:0]       r_irq;
    logic [TO_W-1:0]  r_to_cnt;
    logic [2:0]       r_pending;
    logic [2:0]       r_lost;
    logic             r_timeout;
    logic [CNT_W-1:0] r_svc [3];

    logic [1:0]       w_active_level;
    logic             w_elig_valid;
    logic [1:0]       w_elig_idx;
    logic             w_ack;
    logic [2:0]       w_clear;

    always_ff @(posedge clk or posedge clr) begin : p_sync
        if (clr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // An event is the cycle in which a disagreeing rising level completes its run.
    always_comb begin
        w_db_done = '0;
        w_event   = '0;
        for (int i = 0; i < 3; i++) begin
            w_db_done[i] = (r_sync2[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
            w_event[i]   = w_db_done[i] & r_sync2[i];
        end
    end

    always_ff @(posedge clk or posedge clr) begin : p_debounce
        if (clr) begin
            r_stable <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_done[i]) begin
                    r_db_cnt[i] <= '0;
                    r_stable[i] <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Line numbers are index+1; a line is eligible only above the running level.
    always_comb begin
        w_active_level = 2'd0;
        if (running_in[2])      w_active_level = 2'd3;
        else if (running_in[1]) w_active_level = 2'd2;
        else if (running_in[0]) w_active_level = 2'd1;

        w_elig_valid = 1'b0;
        w_elig_idx   = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (r_pending[i] && ((i + 1) > int'(w_active_level))) begin
                w_elig_valid = 1'b1;
                w_elig_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        w_ack   = (r_state == S_REQ) && running_in[r_grant];
        w_clear = w_ack ? (3'b001 << r_grant) : 3'b000;
    end

    always_ff @(posedge clk or posedge clr) begin : p_fsm
        if (clr) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_irq     <= '0;
            r_to_cnt  <= '0;
            r_pending <= '0;
            r_lost    <= '0;
            r_timeout <= 1'b0;
            for (int i = 0; i < 3; i++) r_svc[i] <= '0;
        end else begin
            // A new event beats a same-cycle acknowledge clear.
            for (int i = 0; i < 3; i++) begin
                if (w_event[i]) begin
                    r_pending[i] <= 1'b1;
                    if (r_pending[i] && !w_clear[i]) r_lost[i] <= 1'b1;
                end else if (w_clear[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_elig_valid) begin
                        r_grant  <= w_elig_idx;
                        r_irq    <= 3'b001 << w_elig_idx;
                        r_to_cnt <= '0;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_svc[r_grant] <= r_svc[r_grant] + 1'b1;
                        r_irq          <= '0;
                        r_state        <= S_IDLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_irq     <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_irq   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq_out      = r_irq;
    assign pending      = r_pending;
    assign active_level = w_active_level;
    assign lost_req     = r_lost;
    assign timeout      = r_timeout;
    assign svc_count    = {r_svc[2], r_svc[1], r_svc[0]};
    assign dbg_state    = (r_state == S_REQ);

endmodule

// File: tb/tb_irq_requester.sv
// Bench for irq_requester: level table, hand-written multi-cycle sequences and a
// randomized run compared each cycle against a behavioural model.
module tb_irq_requester;

    localparam int DB = 16;
    localparam int TO = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic [2:0]    key_in;
    logic [2:0]    running_in;
    logic [2:0]    irq_out;
    logic [2:0]    pending;
    logic [1:0]    active_level;
    logic [2:0]    lost_req;
    logic          timeout;
    logic [3*CW-1:0] svc_count;
    logic          dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    irq_requester #(.DB_CYCLES(DB), .ACK_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .key_in(key_in), .running_in(running_in),
        .irq_out(irq_out), .pending(pending), .active_level(active_level),
        .lost_req(lost_req), .timeout(timeout), .svc_count(svc_count),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        clr = 1'b1;
        running_in = 3'b000;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_irq(input string name, input logic [2:0] exp, input int budget);
        int n = 0;
        while (irq_out == 3'b000 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(irq_out), 64'(exp));
    endtask

    task automatic ack_line(input int ln);
        running_in = 3'b001 << (ln - 1);
        @(negedge clk);
        running_in = 3'b000;
    endtask

    task automatic serve_line1();
        key_in[0] = 1'b1;
        wait_irq("serve_req", 3'b001, DB + 10);
        key_in[0] = 1'b0;
        ack_line(1);
        tick(DB + 4);
    endtask

    // behavioural reference model
    int m_s1[3], m_s2[3], m_stab[3], m_run[3], m_pend[3], m_lost[3], m_svc[3];
    int m_timeout, m_grant, m_age;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_run[i] = 0;
            m_pend[i] = 0; m_lost[i] = 0; m_svc[i] = 0;
        end
        m_timeout = 0;
        m_grant   = -1;
        m_age     = 0;
    endfunction

    function automatic int level_of(input logic [2:0] r);
        int lvl = 0;
        for (int ln = 1; ln <= 3; ln++) if (r[ln-1]) lvl = ln;
        return lvl;
    endfunction

    function automatic void model_step(input logic [2:0] k, input logic [2:0] r);
        int ev[3];
        int clr_line = -1;
        int lvl = level_of(r);
        for (int i = 0; i < 3; i++) begin
            ev[i] = 0;
            if (m_s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_stab[i] = m_s2[i];
                    m_run[i]  = 0;
                    ev[i]     = m_stab[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (m_grant < 0) begin
            for (int ln = 3; ln >= 1; ln--)
                if (m_grant < 0 && m_pend[ln-1] == 1 && ln > lvl) begin
                    m_grant = ln - 1;
                    m_age   = 0;
                end
        end else if (r[m_grant]) begin
            m_svc[m_grant] = (m_svc[m_grant] + 1) % (1 << CW);
            clr_line = m_grant;
            m_grant  = -1;
        end else begin
            m_age++;
            if (m_age == TO) begin
                m_timeout = 1;
                m_grant   = -1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (ev[i] == 1) begin
                if (m_pend[i] == 1 && clr_line != i) m_lost[i] = 1;
                m_pend[i] = 1;
            end else if (clr_line == i) begin
                m_pend[i] = 0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(k[i]);
        end
    endfunction

    function automatic logic [63:0] model_outputs();
        logic [2:0] irq_v, pend_v, lost_v;
        logic [3*CW-1:0] svc_v;
        irq_v = (m_grant >= 0) ? (3'b001 << m_grant) : 3'b000;
        for (int i = 0; i < 3; i++) begin
            pend_v[i] = (m_pend[i] == 1);
            lost_v[i] = (m_lost[i] == 1);
            svc_v[i*CW +: CW] = CW'(m_svc[i]);
        end
        return {29'd0, (m_grant >= 0), (m_timeout == 1), lost_v, pend_v, irq_v, svc_v};
    endfunction

    typedef struct {
        logic [2:0] run;
        logic [1:0] lvl;
    } lvl_vec_t;

    initial begin : watchdog
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        lvl_vec_t tbl[8];
        bit seen;
        bit held_ok;
        int hold[3];
        int bg_hold;
        logic [2:0] kv, bg, ackv;

        tbl[0] = '{3'b000, 2'd0}; tbl[1] = '{3'b001, 2'd1};
        tbl[2] = '{3'b010, 2'd2}; tbl[3] = '{3'b011, 2'd2};
        tbl[4] = '{3'b100, 2'd3}; tbl[5] = '{3'b101, 2'd3};
        tbl[6] = '{3'b110, 2'd3}; tbl[7] = '{3'b111, 2'd3};

        key_in = 3'b000;
        running_in = 3'b000;
        clr = 1'b1;
        #1;
        check("reset_flags", 64'({irq_out, pending, lost_req, timeout, dbg_state}), 64'd0);
        check("reset_svc", 64'(svc_count), 64'd0);
        do_reset();

        // active_level table; running bits outside a request change nothing else
        for (int i = 0; i < 8; i++) begin
            running_in = tbl[i].run;
            #1;
            check("level_table", 64'(active_level), 64'(tbl[i].lvl));
            @(negedge clk);
            check("idle_running", 64'({irq_out, pending}), 64'd0);
        end
        running_in = 3'b000;

        // key held through reset: event DB+2 cycles after release
        key_in[0] = 1'b1;
        do_reset();
        tick(DB + 1);
        check("db_early", 64'(pending), 64'd0);
        tick(1);
        check("db_event", 64'({pending, irq_out}), 64'({3'b001, 3'b000}));
        tick(1);
        check("first_irq", 64'({irq_out, dbg_state}), 64'({3'b001, 1'b1}));
        tick(10);
        key_in[0] = 1'b0;
        ack_line(1);
        check("ack_result", 64'({irq_out, pending}), 64'd0);
        check("ack_svc", 64'(svc_count), 64'h000001);
        tick(DB + 4);
        check("release_no_event", 64'(pending), 64'd0);

        // glitchy key: runs of 10 never qualify
        seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            key_in[0] = (c < 10) || (c >= 11 && c < 21);
            @(negedge clk);
            if (pending != 3'b000 || irq_out != 3'b000) seen = 1'b1;
        end
        check("glitch_no_event", 64'(seen), 64'd0);

        // lines below the running level wait, then issue highest first
        running_in = 3'b010;
        key_in = 3'b011;
        tick(DB + 2);
        check("both_pending", 64'(pending), 64'b011);
        tick(3);
        check("blocked_by_level", 64'(irq_out), 64'd0);
        key_in = 3'b000;
        tick(DB + 4);
        exp_q.delete();
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        running_in = 3'b000;
        wait_irq("order_first", exp_q.pop_front(), 5);
        ack_line(2);
        check("gap_idle", 64'(irq_out), 64'd0);
        tick(1);
        check("order_second", 64'(irq_out), 64'(exp_q.pop_front()));
        ack_line(1);
        check("order_done", 64'(pending), 64'd0);
        check("order_svc", 64'(svc_count), 64'h000102);

        // timeout on line 3 and re-request after one idle cycle
        key_in[2] = 1'b1;
        wait_irq("to_req", 3'b100, DB + 10);
        key_in[2] = 1'b0;
        held_ok = 1'b1;
        for (int k = 1; k < TO; k++) begin
            tick(1);
            if (irq_out != 3'b100) held_ok = 1'b0;
        end
        check("to_hold", 64'(held_ok), 64'd1);
        tick(1);
        check("to_drop", 64'({irq_out, timeout, pending}), 64'({3'b000, 1'b1, 3'b100}));
        tick(1);
        check("to_rereq", 64'(irq_out), 64'b100);
        ack_line(3);
        check("to_svc", 64'({pending, svc_count}), 64'({3'b000, 24'h010102}));

        // second event on a waiting line is lost
        running_in = 3'b010;
        key_in[1] = 1'b1;
        tick(DB + 2);
        key_in[1] = 1'b0;
        tick(DB + 4);
        check("lost_clear", 64'(lost_req), 64'd0);
        key_in[1] = 1'b1;
        tick(DB + 2);
        key_in[1] = 1'b0;
        check("lost_set", 64'({lost_req, pending, irq_out}), 64'({3'b010, 3'b010, 3'b000}));
        running_in = 3'b000;
        wait_irq("lost_grant", 3'b010, 5);
        ack_line(2);
        check("lost_sticky", 64'({lost_req, pending}), 64'({3'b010, 3'b000}));
        tick(DB + 4);

        // event and acknowledge on the same edge: event wins, nothing lost
        do_reset();
        key_in[0] = 1'b1;
        wait_irq("co_req", 3'b001, DB + 10);
        key_in[0] = 1'b0;
        tick(DB + 4);
        key_in[0] = 1'b1;
        tick(DB + 1);
        running_in = 3'b001;
        tick(1);
        running_in = 3'b000;
        key_in[0] = 1'b0;
        check("co_event_wins", 64'({pending, lost_req, irq_out}), 64'({3'b001, 3'b000, 3'b000}));
        check("co_svc", 64'(svc_count), 64'h000001);
        tick(1);
        check("co_rereq", 64'(irq_out), 64'b001);
        ack_line(1);
        tick(DB + 4);

        // service counter wraps modulo 256
        do_reset();
        for (int n = 0; n < 255; n++) serve_line1();
        check("svc_255", 64'(svc_count), 64'h0000ff);
        serve_line1();
        check("svc_wrap", 64'(svc_count), 64'h000000);

        // clear during a request
        for (int n = 0; n < 5; n++) serve_line1();
        check("svc_5", 64'(svc_count), 64'h000005);
        key_in[0] = 1'b1;
        wait_irq("clr_req", 3'b001, DB + 10);
        key_in[0] = 1'b0;
        tick(3);
        #2 clr = 1'b1;
        #1;
        check("clr_async", 64'({irq_out, pending, lost_req, timeout, dbg_state, svc_count}), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("clr_idle", 64'({dbg_state, irq_out, pending}), 64'd0);

        // randomized run against the model
        key_in = 3'b000;
        do_reset();
        model_reset();
        kv = 3'b000;
        bg = 3'b000;
        bg_hold = 0;
        for (int i = 0; i < 3; i++) hold[i] = $urandom_range(2, 40);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rand_outputs",
                  {29'd0, dbg_state, timeout, lost_req, pending, irq_out, svc_count},
                  model_outputs());
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    kv[i] = ~kv[i];
                    hold[i] = $urandom_range(2, 40);
                end else begin
                    hold[i]--;
                end
            end
            if (bg_hold == 0) begin
                bg = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
                bg_hold = $urandom_range(5, 60);
            end else begin
                bg_hold--;
            end
            ackv = (m_grant >= 0 && $urandom_range(0, 5) == 0) ? (3'b001 << m_grant) : 3'b000;
            key_in = kv;
            running_in = bg | ackv;
            #1;
            check("rand_level", 64'(active_level), 64'(level_of(running_in)));
            model_step(kv, running_in);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
